// File: rtl/byte_lanes_dly_seq_if.sv
// Shared bus between the PHY control register file (master) and the
// byte-lane delay sequencer (slave).
interface byte_lanes_dly_seq_if #(
  parameter int NUM_LANES = 2,
  parameter int LANE_AW   = 1,
  parameter int DLY_WIDTH = 8
);
  logic                 cfg_we;
  logic [LANE_AW-1:0]   cfg_lane;
  logic [4:0]           cfg_addr;
  logic [DLY_WIDTH-1:0] cfg_data;
  logic [DLY_WIDTH-1:0] cfg_rdata;
  logic                 apply;
  logic [DLY_WIDTH:0]   ofs;
  logic [1:0]           ld_mask;
  logic                 busy;
  logic                 done;
  logic [DLY_WIDTH-1:0] dly_data;
  logic [4:0]           dly_addr;
  logic [NUM_LANES-1:0] ld_delay;
  logic                 set;

  modport master (
    output cfg_we, cfg_lane, cfg_addr, cfg_data, apply, ofs, ld_mask,
    input  cfg_rdata, busy, done, dly_data, dly_addr, ld_delay, set
  );

  modport slave (
    input  cfg_we, cfg_lane, cfg_addr, cfg_data, apply, ofs, ld_mask,
    output cfg_rdata, busy, done, dly_data, dly_addr, ld_delay, set
  );
endinterface

// File: rtl/byte_lanes_dly_seq.sv
// Delay-programming sequencer: shadows every lane's IDELAY/ODELAY taps and streams
// them, offset and saturated, to the byte lanes followed by one broadcast set.
module byte_lanes_dly_seq #(
  parameter int NUM_LANES = 2,
  parameter int LANE_AW   = 1,
  parameter int DLY_WIDTH = 8,
  parameter int SET_GAP   = 2
) (
  input logic                clk_div,
  input logic                rst_n,
  byte_lanes_dly_seq_if.slave bus
);
  // Addresses 0-9 map to entries 0-9, addresses 16-24 to entries 10-18.
  localparam int NUM_ENT = 19;
  localparam logic [DLY_WIDTH-1:0] DLY_MAX = '1;

  typedef enum logic [2:0] {IDLE, LOAD, GAP, SET, DONE} state_t;

  function automatic logic addr_ok(input logic [4:0] a);
    return (a <= 5'd9) || ((a >= 5'd16) && (a <= 5'd24));
  endfunction

  function automatic logic [4:0] ent_idx(input logic [4:0] a);
    return (a >= 5'd16) ? (a - 5'd6) : a;
  endfunction

  logic [NUM_LANES-1:0][NUM_ENT-1:0][DLY_WIDTH-1:0] shadow;
  logic [DLY_WIDTH-1:0] rdata_q;

  state_t               state;
  logic                 busy_q, done_q, set_q;
  logic [NUM_LANES-1:0] ld_q;
  logic [DLY_WIDTH-1:0] data_q;
  logic [4:0]           daddr_q;
  logic [LANE_AW-1:0]   lane_q;
  logic [4:0]           addr_q;
  logic [3:0]           gap_q;
  logic [DLY_WIDTH:0]   ofs_q;
  logic [1:0]           mask_q;

  logic                 lane_ok, cfg_ok, wr_en;
  logic [DLY_WIDTH+1:0] sum;
  logic [DLY_WIDTH-1:0] sat;
  logic [4:0]           next_addr;
  logic                 lane_end;

  assign lane_ok = ({1'b0, bus.cfg_lane} < (LANE_AW+1)'(NUM_LANES));
  assign cfg_ok  = addr_ok(bus.cfg_addr) && lane_ok;
  assign wr_en   = bus.cfg_we && cfg_ok && !busy_q;

  // Two extra bits hold the full signed range of shadow + offset without wrap.
  assign sum = {2'b00, shadow[lane_q][ent_idx(addr_q)]} + {ofs_q[DLY_WIDTH], ofs_q};
  assign sat = sum[DLY_WIDTH+1] ? '0 : (sum[DLY_WIDTH] ? DLY_MAX : sum[DLY_WIDTH-1:0]);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    next_addr = addr_q + 5'd1;
    lane_end  = 1'b0;
    if (addr_q == 5'd9) begin
      if (mask_q[1]) next_addr = 5'd16;
      else           lane_end  = 1'b1;
    end else if (addr_q == 5'd24) begin
      lane_end = 1'b1;
    end
  end

  always_ff @(posedge clk_div) begin
    if (!rst_n) begin
      // NOTE: the shadow table must read back zero after reset, so the whole memory is cleared here.
      shadow  <= '0;
      rdata_q <= '0;
    end else begin
      if (wr_en) shadow[bus.cfg_lane][ent_idx(bus.cfg_addr)] <= bus.cfg_data;
      // A write to the entry being read is forwarded so readback shows the new value.
      if (!cfg_ok)    rdata_q <= '0;
      else if (wr_en) rdata_q <= bus.cfg_data;
      else            rdata_q <= shadow[bus.cfg_lane][ent_idx(bus.cfg_addr)];
    end
  end

  always_ff @(posedge clk_div) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      set_q   <= 1'b0;
      ld_q    <= '0;
      data_q  <= '0;
      daddr_q <= '0;
      lane_q  <= '0;
      addr_q  <= '0;
      gap_q   <= '0;
      ofs_q   <= '0;
      mask_q  <= '0;
    end else begin
      // NOTE: sequential state uses <= so every register sees pre-edge values of the others.
      ld_q   <= '0;
      set_q  <= 1'b0;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          busy_q <= 1'b0;
          // busy_q is still high on the first IDLE edge after DONE, which blocks a stale apply.
          if (bus.apply && !busy_q) begin
            busy_q <= 1'b1;
            ofs_q  <= bus.ofs;
            mask_q <= bus.ld_mask;
            lane_q <= '0;
            addr_q <= bus.ld_mask[0] ? 5'd0 : 5'd16;
            gap_q  <= '0;
            if (bus.ld_mask != 2'b00) state <= LOAD;
            else                      state <= (SET_GAP == 0) ? SET : GAP;
          end
        end
        LOAD: begin
          ld_q    <= NUM_LANES'(1) << lane_q;
          data_q  <= sat;
          daddr_q <= addr_q;
          if (lane_end) begin
            if (lane_q == LANE_AW'(NUM_LANES - 1)) begin
              state <= (SET_GAP == 0) ? SET : GAP;
            end else begin
              lane_q <= lane_q + LANE_AW'(1);
              addr_q <= mask_q[0] ? 5'd0 : 5'd16;
            end
          end else begin
            addr_q <= next_addr;
          end
        end
        GAP: begin
          gap_q <= gap_q + 4'd1;
          if (gap_q == 4'(SET_GAP - 1)) state <= SET;
        end
        SET: begin
          set_q <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cfg_rdata = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.set       = set_q;
  assign bus.ld_delay  = ld_q;
  assign bus.dly_data  = data_q;
  assign bus.dly_addr  = daddr_q;
endmodule

// File: tb/tb_byte_lanes_dly_seq.sv
// Self-checking bench for byte_lanes_dly_seq: directed steps plus random shadow
// contents and offsets, checked against a table-and-arithmetic reference model.
module tb_byte_lanes_dly_seq;
  localparam int NL  = 2;
  localparam int LAW = 1;
  localparam int DW  = 8;
  localparam int GAP = 2;
  localparam int MAXV = (1 << DW) - 1;

  logic clk_div = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_div = ~clk_div;

  byte_lanes_dly_seq_if #(.NUM_LANES(NL), .LANE_AW(LAW), .DLY_WIDTH(DW)) bus ();

  byte_lanes_dly_seq #(.NUM_LANES(NL), .LANE_AW(LAW), .DLY_WIDTH(DW), .SET_GAP(GAP)) dut (
    .clk_div(clk_div),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  typedef struct {
    int lane;
    int addr;
    int data;
  } ent_t;

  int tests = 0;
  int fails = 0;
  int sh [NL][32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit valid(input int lane, input int addr);
    return (lane < NL) && ((addr >= 0 && addr <= 9) || (addr >= 16 && addr <= 24));
  endfunction

  function automatic int sat(input int v);
    if (v < 0) return 0;
    if (v > MAXV) return MAXV;
    return v;
  endfunction

  function automatic int model_rd(input int lane, input int addr);
    return valid(lane, addr) ? sh[lane][addr] : 0;
  endfunction

  task automatic clear_model();
    for (int l = 0; l < NL; l++)
      for (int a = 0; a < 32; a++) sh[l][a] = 0;
  endtask

  // Write while idle; the readback port points at the same entry, so the next cycle shows the new value.
  task automatic wr(input int lane, input int addr, input int data);
    @(negedge clk_div);
    bus.cfg_we   = 1'b1;
    bus.cfg_lane = LAW'(lane);
    bus.cfg_addr = 5'(addr);
    bus.cfg_data = DW'(data);
    @(negedge clk_div);
    bus.cfg_we = 1'b0;
    if (valid(lane, addr)) sh[lane][addr] = data;
    check($sformatf("wr_fwd_l%0d_a%0d", lane, addr), 32'(bus.cfg_rdata), 32'(model_rd(lane, addr)));
  endtask

  task automatic rd(input int lane, input int addr);
    @(negedge clk_div);
    bus.cfg_lane = LAW'(lane);
    bus.cfg_addr = 5'(addr);
    @(negedge clk_div);
    check($sformatf("rd_l%0d_a%0d", lane, addr), 32'(bus.cfg_rdata), 32'(model_rd(lane, addr)));
  endtask

  // One apply, watched cycle by cycle until busy has dropped. With inject set, a
  // write and a second apply are presented while the load is running.
  task automatic run_seq(input logic [DW:0] o, input logic [1:0] m, input bit inject);
    ent_t q[$];
    ent_t e;
    int n, t_set, oi;
    logic [31:0] exp_ld;
    oi = int'($signed(o));
    for (int l = 0; l < NL; l++)
      for (int a = 0; a < 32; a++)
        if ((m[0] && a <= 9) || (m[1] && a >= 16 && a <= 24)) begin
          e.lane = l;
          e.addr = a;
          e.data = sat(sh[l][a] + oi);
          q.push_back(e);
        end
    n     = q.size();
    t_set = n + 2 + GAP;
    @(negedge clk_div);
    bus.apply   = 1'b1;
    bus.ofs     = o;
    bus.ld_mask = m;
    for (int c = 1; c <= t_set + 3; c++) begin
      @(negedge clk_div);
      if (c == 1) bus.apply = 1'b0;
      exp_ld = 32'd0;
      if (c >= 2 && c <= n + 1) exp_ld = 32'(1) << q[c-2].lane;
      check($sformatf("ld_delay_c%0d", c), 32'(bus.ld_delay), exp_ld);
      if (exp_ld != 32'd0) begin
        check($sformatf("dly_addr_c%0d", c), 32'(bus.dly_addr), 32'(q[c-2].addr));
        check($sformatf("dly_data_c%0d", c), 32'(bus.dly_data), 32'(q[c-2].data));
      end
      check($sformatf("set_c%0d", c),  32'(bus.set),  32'(c == t_set));
      check($sformatf("done_c%0d", c), 32'(bus.done), 32'(c == t_set + 1));
      check($sformatf("busy_c%0d", c), 32'(bus.busy), 32'(c <= t_set + 1));
      if (inject && c == 3) begin
        bus.cfg_we   = 1'b1;
        bus.cfg_lane = '0;
        bus.cfg_addr = 5'd0;
        bus.cfg_data = DW'(sh[0][0] ^ 8'hA5);
        bus.apply    = 1'b1;
      end
      if (inject && c == 5) begin
        bus.cfg_we = 1'b0;
        bus.apply  = 1'b0;
      end
    end
  endtask

  initial begin
    bus.cfg_we   = 1'b0;
    bus.cfg_lane = '0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    bus.apply    = 1'b0;
    bus.ofs      = '0;
    bus.ld_mask  = '0;
    clear_model();

    repeat (3) @(negedge clk_div);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_done",      32'(bus.done),      32'd0);
    check("rst_set",       32'(bus.set),       32'd0);
    check("rst_ld_delay",  32'(bus.ld_delay),  32'd0);
    check("rst_dly_data",  32'(bus.dly_data),  32'd0);
    check("rst_dly_addr",  32'(bus.dly_addr),  32'd0);
    check("rst_cfg_rdata", 32'(bus.cfg_rdata), 32'd0);
    rst_n = 1'b1;

    // Input delays only: 18 pulses, the last one lane 1 / addr 24 carrying 8'h35.
    wr(1, 24, 'h35);
    run_seq('0, 2'b10, 1'b0);

    // Saturation at both ends; the shadow keeps its programmed values.
    wr(0, 8, 'hFC);
    wr(0, 24, 'h03);
    run_seq(9'd9, 2'b11, 1'b0);
    run_seq(9'h1FB, 2'b11, 1'b0);
    rd(0, 8);
    rd(0, 24);

    // Empty mask: no loads, set after the gap only.
    run_seq(9'h0F0, 2'b00, 1'b0);

    // Invalid addresses are dropped and read back as zero.
    wr(0, 12, 'h77);
    wr(1, 30, 'h66);
    rd(0, 12);
    rd(1, 30);

    // Random shadow contents and random offset/mask applies.
    for (int l = 0; l < NL; l++)
      for (int a = 0; a <= 24; a++)
        if (valid(l, a)) wr(l, a, int'($urandom_range(0, MAXV)));
    repeat (6) run_seq(9'($urandom), 2'($urandom), 1'b0);

    // Write and second apply while busy are both ignored.
    run_seq(9'($urandom), 2'b11, 1'b1);
    rd(0, 0);
    repeat (6) rd(int'($urandom_range(0, NL - 1)), int'($urandom_range(0, 31)));

    // Reset in the middle of a load aborts at once and clears the shadow.
    wr(0, 3, 'h5A);
    @(negedge clk_div);
    bus.apply   = 1'b1;
    bus.ofs     = '0;
    bus.ld_mask = 2'b11;
    @(negedge clk_div);
    bus.apply = 1'b0;
    repeat (4) @(negedge clk_div);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk_div);
    check("abort_ld_delay", 32'(bus.ld_delay), 32'd0);
    check("abort_set",      32'(bus.set),      32'd0);
    check("abort_busy",     32'(bus.busy),     32'd0);
    check("abort_done",     32'(bus.done),     32'd0);
    rst_n = 1'b1;
    clear_model();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_div);
      check($sformatf("post_rst_set_%0d", c), 32'(bus.set), 32'd0);
    end
    rd(0, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
